multdiv_unit: RTL and testbench
===============================

# multdiv_unit

Parametrised iterative signed multiply/divide unit for the processor's execute stage, handling `mul` (ALU opcode 00110) and `div` (ALU opcode 00111). The single-cycle ALU produces results combinationally. This block is different: it takes several cycles per operation and reports completion through a one-cycle ready pulse, so the core can stall while it runs. Data width is a parameter, and the iteration count scales with it.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4).
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- data_operandA  in  WIDTH  multiplicand or dividend, two's complement.
- data_operandB  in  WIDTH  multiplier or divisor, two's complement.
- ctrl_MULT  in  1  start-multiply strobe, sampled every cycle.
- ctrl_DIV  in  1  start-divide strobe, sampled every cycle.
- data_result  out  WIDTH  product or quotient; reset value 0.
- data_exception  out  1  overflow or divide-by-zero flag, valid with data_resultRDY; reset value 0.
- data_resultRDY  out  1  one-cycle completion pulse; reset value 0.
- busy  out  1  high from the cycle after a start until data_resultRDY; reset value 0.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset forces IDLE.
- Start: a rising edge with ctrl_MULT=1 or ctrl_DIV=1 does four things:
  - latches |A| and |B|;
  - latches the result sign (A[msb] XOR B[msb]);
  - clears the iteration counter ($clog2(WIDTH+1) bits);
  - enters MUL or DIV.
- ctrl_MULT and ctrl_DIV both high: multiply wins.
- A start in any state, including MUL, DIV or DONE, aborts the current operation and restarts with the new operands. No RDY is issued for the aborted operation.
- MUL: unsigned radix-2 shift-add over WIDTH iterations into a 2·WIDTH-bit product register.
- DIV: unsigned restoring division over WIDTH iterations. The quotient is kept; the remainder is discarded.
- After WIDTH iterations the unit enters DONE and performs the fixup:
  - negates the magnitude if the result sign is 1;
  - registers data_result and data_exception;
  - pulses data_resultRDY;
  - returns to IDLE on the next edge.
- Multiply exception: set when the full signed 2·WIDTH-bit product does not fit in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal. data_result is the low WIDTH bits.
- Divide:
  - rounding truncates toward zero;
  - divisor 0: data_result=0, data_exception=1;
  - most-negative ÷ −1: data_result = most-negative, data_exception=1;
  - neither case shortens the latency.
- Zero operands follow the normal path with the normal latency.
- data_result and data_exception hold their values until the next operation's DONE or a reset.

## Timing
- Start edge E0. Iterations run on edges E1..E_WIDTH. DONE is entered on E_WIDTH.
- data_resultRDY is high for the cycle following edge E_(WIDTH+1), so it is first seen high WIDTH+1 cycles after the start edge.
- It is low again after E_(WIDTH+2) unless a restart intervenes.
- busy is high after E0 and low in the same cycle that RDY is high.
- ctrl_* asserted in the RDY cycle starts a new operation. RDY still pulses for the completed one.
- Reset low mid-operation: state returns to IDLE and all outputs return to 0 asynchronously. The operation is lost and no RDY is issued.
- Strobes are not level-sensitive. Holding ctrl_MULT high restarts the operation every cycle, so the core must pulse it.

## Structure
- Package multdiv_pkg holds:
  - the state enum (IDLE/MUL/DIV/DONE);
  - the ALU opcode constants OP_MUL=5'b00110 and OP_DIV=5'b00111, shared with the processor's decode.
- Sub-module multdiv_addsub: a WIDTH+1-bit add/subtract cell with carry-out. It is shared by the multiply accumulate and the divide trial subtraction, selected by state.
- The counter, magnitude/negate logic and the FSM are inline in multdiv_unit.

## Test plan
(WIDTH=32 unless stated.)
- Multiply: A=7, B=−6 pulsed on ctrl_MULT → RDY 33 cycles later, result 0xFFFFFFD6 (−42), exception 0, busy low in the RDY cycle.
- Multiply overflow:
  - A=0x40000000, B=4 → result 0x00000000, exception 1;
  - A=0xFFFF, B=0x10000 → 0xFFFF0000, exception 1.
- Divide:
  - A=−7, B=2 → −3 (0xFFFFFFFD), exception 0;
  - A=5, B=0 → 0, exception 1;
  - A=0x80000000, B=−1 → 0x80000000, exception 1.
- Restart: start multiply 3×3, then at E10 pulse ctrl_DIV with 100÷7 → exactly one RDY, at E10+33, result 14.
- Reset: drop reset at E5 of a divide → outputs 0 immediately; after release, no RDY appears.
- Parameter sweep WIDTH=8: 200 random signed mul/div pairs checked against a signed reference model (WIDTH-bit truncated product, exception rules above) → RDY at start+9 each time; back-to-back start in the RDY cycle accepted.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_t : control FSM states (IDLE, MUL, DIV, DONE)
//   OP_MUL  : ALU opcode for mul, shared with the processor decode
//   OP_DIV  : ALU opcode for div, shared with the processor decode
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

endpackage

// File: rtl/multdiv_addsub.sv
// Add/subtract cell shared by the multiply accumulate and the divide trial
// subtraction.
//   op_x, op_y : operands (WIDTH bits, unsigned)
//   sub        : 0 -> op_x + op_y, 1 -> op_x - op_y
//   sum        : WIDTH-bit result
//   carry      : carry-out; when subtracting, 1 means op_x >= op_y
module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] y_sel;

    always_comb begin
        y_sel        = sub ? ~op_y : op_y;
        {carry, sum} = {1'b0, op_x} + {1'b0, y_sel} + {{WIDTH{1'b0}}, sub};
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
//   clock          : master clock, rising edge
//   reset          : asynchronous active-low reset
//   data_operandA  : multiplicand / dividend (two's complement)
//   data_operandB  : multiplier / divisor (two's complement)
//   ctrl_MULT      : start-multiply strobe (wins over ctrl_DIV)
//   ctrl_DIV       : start-divide strobe
//   data_result    : product (low WIDTH bits) or quotient
//   data_exception : multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY : one-cycle completion pulse
//   busy           : high from the cycle after a start until the RDY cycle
// Magnitudes are processed unsigned over WIDTH iterations; the sign is
// applied in DONE.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign;
    logic               op_div;
    // Multiply: {product_hi, multiplier shifting out}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;

    logic               start;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     as_x;
    logic [WIDTH:0]     as_y;
    logic               as_sub;
    logic [WIDTH:0]     as_sum;
    logic               as_carry;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;
    logic [WIDTH-1:0]   quo_s;
    logic               div_zero;
    logic               div_ovf;

    assign start = ctrl_MULT | ctrl_DIV;

    // The most-negative value maps to 2^(WIDTH-1), still representable unsigned.
    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? (~data_operandA + ONE_W) : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? (~data_operandB + ONE_W) : data_operandB;
    end

    // Adder operand select: accumulate |A| into the product high half, or
    // trial-subtract |B| from the left-shifted partial remainder.
    always_comb begin
        as_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        as_y   = {1'b0, mag_a};
        as_sub = 1'b0;
        if (state == DIV) begin
            as_x   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            as_y   = {1'b0, mag_b};
            as_sub = 1'b1;
        end
    end

    multdiv_addsub #(
        .WIDTH (WIDTH + 1)
    ) u_addsub (
        .op_x  (as_x),
        .op_y  (as_y),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    // Sign fixup and exception detection on the finished magnitude.
    always_comb begin
        prod_s   = sign ? (~acc + ONE_2W) : acc;
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        mul_exc  = !((&prod_top) || !(|prod_top));
        quo_s    = sign ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
        div_zero = (mag_b == '0);
        // A positive quotient with its msb set only arises from min / -1.
        div_ovf  = !sign && acc[WIDTH-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mag_a          <= '0;
            mag_b          <= '0;
            sign           <= 1'b0;
            op_div         <= 1'b0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                mag_a  <= abs_a;
                mag_b  <= abs_b;
                sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                cnt    <= '0;
                busy   <= 1'b1;
                op_div <= !ctrl_MULT;
                if (ctrl_MULT) begin
                    acc   <= {{WIDTH{1'b0}}, abs_b};
                    state <= MUL;
                end else begin
                    acc   <= {{WIDTH{1'b0}}, abs_a};
                    state <= DIV;
                end
            end else begin
                case (state)
                    IDLE: ;
                    MUL: begin
                        if (acc[0])
                            acc <= {as_sum, acc[WIDTH-1:1]};
                        else
                            acc <= {1'b0, acc[2*WIDTH-1:1]};
                        cnt <= cnt + CNT_ONE;
                        if (cnt == LAST)
                            state <= DONE;
                    end
                    DIV: begin
                        if (as_carry)
                            acc <= {as_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        cnt <= cnt + CNT_ONE;
                        if (cnt == LAST)
                            state <= DONE;
                    end
                    DONE: begin
                        if (op_div) begin
                            if (div_zero) begin
                                data_result    <= '0;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= quo_s;
                                data_exception <= div_ovf;
                            end
                        end else begin
                            data_result    <= prod_s[WIDTH-1:0];
                            data_exception <= mul_exc;
                        end
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock;
    logic        reset;

    logic [31:0] a32, b32, res32;
    logic        mult32, div32, exc32, rdy32, busy32;
    logic [7:0]  a8, b8, res8;
    logic        mult8, div8, exc8, rdy8, busy8;

    int n_checks;
    int n_errors;

    multdiv_unit #(.WIDTH(32)) dut32 (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (a32),
        .data_operandB  (b32),
        .ctrl_MULT      (mult32),
        .ctrl_DIV       (div32),
        .data_result    (res32),
        .data_exception (exc32),
        .data_resultRDY (rdy32),
        .busy           (busy32)
    );

    multdiv_unit #(.WIDTH(8)) dut8 (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (a8),
        .data_operandB  (b8),
        .ctrl_MULT      (mult8),
        .ctrl_DIV       (div8),
        .data_result    (res8),
        .data_exception (exc8),
        .data_resultRDY (rdy8),
        .busy           (busy8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Signed reference: exact product / truncating quotient, then range test.
    function automatic logic [32:0] model(input int w, input bit is_div,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r, lo, hi;
        logic   ex;
        if (w == 8) begin
            sa = longint'($signed(a[7:0]));
            sb = longint'($signed(b[7:0]));
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        lo = -(longint'(1) <<< (w - 1));
        hi = -lo - 1;
        if (!is_div) begin
            r  = sa * sb;
            ex = (r < lo) || (r > hi);
        end else if (sb == 0) begin
            r  = 0;
            ex = 1'b1;
        end else begin
            r  = sa / sb;
            ex = (r > hi);
        end
        return {ex, r[31:0]};
    endfunction

    function automatic logic cur_rdy(input bit w8);
        return w8 ? rdy8 : rdy32;
    endfunction

    // Called at posedge+#1; the strobe is sampled on the next edge (E0).
    task automatic go(input bit w8, input bit is_div, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; mult8 = !is_div; div8 = is_div;
        end else begin
            a32 = a; b32 = b; mult32 = !is_div; div32 = is_div;
        end
        @(posedge clock); #1;
        mult8 = 1'b0; div8 = 1'b0; mult32 = 1'b0; div32 = 1'b0;
        check("busy_after_start", w8 ? busy8 : busy32, 1);
    endtask

    task automatic wait_rdy(input bit w8, output int n);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!cur_rdy(w8) && n <= 100);
    endtask

    task automatic do_op(input string tag, input bit w8, input bit is_div,
                         input logic [31:0] a, input logic [31:0] b, input bit fall);
        int          n;
        int          w;
        logic [32:0] exp;
        w   = w8 ? 8 : 32;
        exp = model(w, is_div, a, b);
        go(w8, is_div, a, b);
        wait_rdy(w8, n);
        check({tag, "_latency"}, n, w + 1);
        if (w8) begin
            check({tag, "_result"}, res8, exp[7:0]);
            check({tag, "_exc"}, exc8, exp[32]);
            check({tag, "_busy_rdy"}, busy8, 0);
        end else begin
            check({tag, "_result"}, res32, exp[31:0]);
            check({tag, "_exc"}, exc32, exp[32]);
            check({tag, "_busy_rdy"}, busy32, 0);
        end
        if (fall) begin
            @(posedge clock); #1;
            check({tag, "_rdy_fall"}, cur_rdy(w8), 0);
            if (!w8) check({tag, "_hold"}, res32, exp[31:0]);
        end
    endtask

    initial begin
        int          n;
        int          cnt;
        logic [4:0]  op;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_errors = 0;
        a32 = '0; b32 = '0; mult32 = 1'b0; div32 = 1'b0;
        a8  = '0; b8  = '0; mult8  = 1'b0; div8  = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_result", res32, 0);
        check("rst_exc", exc32, 0);
        check("rst_rdy", rdy32, 0);
        check("rst_busy", busy32, 0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // Directed WIDTH=32 cases
        do_op("mul_7x-6",  1'b0, 1'b0, 32'd7,          32'hFFFF_FFFA, 1'b1);
        check("mul_7x-6_const", res32, 64'hFFFF_FFD6);
        do_op("mul_ovf1",  1'b0, 1'b0, 32'h4000_0000, 32'd4,         1'b1);
        check("mul_ovf1_exc_const", exc32, 1);
        do_op("mul_ovf2",  1'b0, 1'b0, 32'h0000_FFFF, 32'h0001_0000, 1'b1);
        check("mul_ovf2_const", res32, 64'hFFFF_0000);
        do_op("div_-7/2",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         1'b1);
        check("div_-7/2_const", res32, 64'hFFFF_FFFD);
        do_op("div_by0",   1'b0, 1'b1, 32'd5,          32'd0,         1'b1);
        do_op("div_min",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div_min_const", res32, 64'h8000_0000);
        do_op("mul_zero",  1'b0, 1'b0, 32'd0,          32'hFFFF_FFFB, 1'b1);

        // Restart: multiply aborted at E10 by a divide
        go(1'b0, 1'b0, 32'd3, 32'd3);
        repeat (9) @(posedge clock);
        #1;
        go(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(1'b0, n);
        check("restart_latency", n, 33);
        check("restart_result", res32, 14);
        check("restart_exc", exc32, 0);
        cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (rdy32) cnt++;
        end
        check("restart_single_rdy", cnt, 0);

        // Reset in the middle of a divide
        go(1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_result", res32, 0);
        check("midrst_exc", exc32, 0);
        check("midrst_rdy", rdy32, 0);
        check("midrst_busy", busy32, 0);
        @(negedge clock); reset = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (rdy32) cnt++;
        end
        check("midrst_no_rdy", cnt, 0);

        // WIDTH=8 random sweep, each start issued in the previous RDY cycle
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL;
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: rb = 32'h00;
                1: begin ra = 32'h80; rb = 32'hFF; end
                2: ra = 32'h00;
                default: ;
            endcase
            do_op("rnd8", 1'b1, op == OP_DIV, ra, rb, 1'b0);
        end
        @(posedge clock); #1;
        check("rnd8_rdy_fall", rdy8, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
